adam_periph_uart_cfg_ctrl: RTL and testbench
============================================

// Module: adam_periph_uart_cfg_ctrl
// PURPOSE
//  Sequences safe reconfiguration of one UART TX/RX engine pair. Holds live config (parity, length,
//  stop bits, baud divisor) driven to both engines. A host write is applied only after both engines
//  ack pause (config may change only while req&&ack). Also relays system pause to both engines.
// PARAMETERS
//  DATA_WIDTH    32      width of baud_rate / divisor fields
//  RST_BAUD      868     live baud_rate value after reset (clk cycles per bit)
//  RST_DLEN      8       live data_length after reset
// PORTS
//  clk              in   1   clock
//  rst              in   1   reset, synchronous, active-high
//  sys_pause_req    in   1   system pause request (ADAM pause protocol)
//  sys_pause_ack    out  1   system pause acknowledge
//  cfg_valid        in   1   host config write valid
//  cfg_ready        out  1   config write accepted when valid&&ready
//  cfg_parity_sel   in   1   requested parity_select
//  cfg_parity_ctl   in   1   requested parity_control
//  cfg_data_len     in   4   requested data_length, legal 5..9
//  cfg_stop_bits    in   1   requested stop_bits (0: 1 stop, 1: 2 stop)
//  cfg_baud         in   DW  requested baud_rate, legal >= 2
//  cfg_err          out  1   1-cycle pulse: accepted write was illegal and discarded
//  busy             out  1   1 when state != RUN
//  tx_pause_req/rx_pause_req   out 1  pause request to TX / RX engine
//  tx_pause_ack/rx_pause_ack   in  1  pause acknowledge from TX / RX engine
//  parity_select, parity_control, stop_bits  out 1  live config
//  data_length out 4, baud_rate out DW               live config
// BEHAVIOUR
//  - All outputs registered. Reset: state HALTED, tx/rx_pause_req=1, sys_pause_ack=1, cfg_ready=1,
//    cfg_err=0, busy=1, pending=0, live cfg = {0,0,RST_DLEN,0,RST_BAUD}. Engines reset with ack=1.
//  - States: RUN, PAUSING, APPLY, HALTED, RESUMING. pause_req=0 in RUN/RESUMING, 1 otherwise.
//    sys_pause_ack=1 only in HALTED. cfg_ready=1 only in RUN/HALTED with pending=0.
//  - Accept (valid&&ready): fields checked; illegal (len<5, len>9, baud<2) -> cfg_err next cycle,
//    no state change. Legal -> latched into shadow regs, pending=1.
//  - RUN: legal accept -> PAUSING. Else sys_pause_req -> PAUSING. Accept + sys_pause_req same cycle
//    -> PAUSING with pending=1 (both honoured).
//  - PAUSING: wait tx_ack&&rx_ack (both high same cycle) -> APPLY if pending, else HALTED.
//  - APPLY: exactly 1 cycle; shadow -> live cfg, pending=0; next HALTED if sys_pause_req else RESUMING.
//  - HALTED: legal accept -> APPLY (engines already paused). Else !sys_pause_req -> RESUMING;
//    sys_pause_ack drops the cycle the state leaves HALTED.
//  - RESUMING: wait !tx_ack && !rx_ack -> RUN. sys_pause_req reasserted here -> PAUSING (no deadlock).
//  - Live cfg changes only in APPLY -> cycle after APPLY, both acks still 1.
//  - Latency RUN write to live cfg: accept cycle + PAUSING (>=1, engine-bound) + APPLY = min 3 cycles.
//  - One engine never idles (ack stuck 0): controller waits indefinitely in PAUSING; no timeout.
//  - rst mid-sequence: immediate return to reset values; shadow/pending discarded.
// TESTING
//  - Reset, sys_pause_req=0, engines ack 1->0 after 2 cycles -> RUN in 3-4 cycles, live baud=868, len=8.
//  - RUN, write len=7 baud=434 parity_ctl=1 -> pause_req=1, live unchanged until both acks high,
//    APPLY 1 cycle, then RESUMING -> RUN; cfg_ready low throughout.
//  - TX ack at cycle 3, RX ack at cycle 10 -> APPLY no earlier than cycle after RX ack.
//  - Write len=4, then len=10, then baud=1 -> three cfg_err pulses, state stays RUN, live cfg unchanged.
//  - sys_pause_req + cfg write same cycle -> APPLY then HALTED, sys_pause_ack=1; drop req -> RUN.
//  - rst asserted in PAUSING with pending write -> HALTED, live cfg = reset values, pending=0.

Source files
------------

// File: rtl/adam_periph_uart_cfg_ctrl.sv
// Reconfiguration sequencer for one UART TX/RX engine pair: owns the live line config and
// only swaps in a host write while both engines hold pause acknowledge.
module adam_periph_uart_cfg_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RST_BAUD   = 868,
    parameter int unsigned RST_DLEN   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sys_pause_req,
    output logic                  sys_pause_ack,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic                  cfg_parity_sel,
    input  logic                  cfg_parity_ctl,
    input  logic [3:0]            cfg_data_len,
    input  logic                  cfg_stop_bits,
    input  logic [DATA_WIDTH-1:0] cfg_baud,
    output logic                  cfg_err,
    output logic                  busy,
    output logic                  tx_pause_req,
    output logic                  rx_pause_req,
    input  logic                  tx_pause_ack,
    input  logic                  rx_pause_ack,
    output logic                  parity_select,
    output logic                  parity_control,
    output logic                  stop_bits,
    output logic [3:0]            data_length,
    output logic [DATA_WIDTH-1:0] baud_rate
);

    localparam int unsigned LEN_W = 4;
    localparam logic [LEN_W-1:0]      LEN_MIN   = LEN_W'(5);
    localparam logic [LEN_W-1:0]      LEN_MAX   = LEN_W'(9);
    localparam logic [DATA_WIDTH-1:0] BAUD_MIN  = DATA_WIDTH'(2);
    localparam logic [LEN_W-1:0]      DLEN_RST  = LEN_W'(RST_DLEN);
    localparam logic [DATA_WIDTH-1:0] BAUD_RST  = DATA_WIDTH'(RST_BAUD);

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        PAUSING  = 3'd1,
        APPLY    = 3'd2,
        HALTED   = 3'd3,
        RESUMING = 3'd4
    } state_t;

    state_t state, state_next;
    logic   pending, pending_next;

    logic   accept, legal, take;
    logic   pause_req_next, sys_ack_next, ready_next, busy_next, err_next;

    logic                  sh_parity_sel;
    logic                  sh_parity_ctl;
    logic                  sh_stop_bits;
    logic [LEN_W-1:0]      sh_data_len;
    logic [DATA_WIDTH-1:0] sh_baud;

    // Handshake and field legality of the incoming host write.
    always_comb begin
        accept = cfg_valid && cfg_ready;
        legal  = (cfg_data_len >= LEN_MIN) && (cfg_data_len <= LEN_MAX) && (cfg_baud >= BAUD_MIN);
        take   = accept && legal;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= HALTED;
            pending <= 1'b0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
        end
    end

    // Next state plus next values of the registered outputs, derived from the next state.
    always_comb begin
        state_next   = state;
        pending_next = pending;

        case (state)
            RUN: begin
                if (take || sys_pause_req) state_next = PAUSING;
            end
            PAUSING: begin
                if (tx_pause_ack && rx_pause_ack) state_next = pending ? APPLY : HALTED;
            end
            APPLY: begin
                state_next = sys_pause_req ? HALTED : RESUMING;
            end
            HALTED: begin
                if (take)                state_next = APPLY;
                else if (!sys_pause_req) state_next = RESUMING;
            end
            RESUMING: begin
                // A fresh system pause wins over finishing the resume.
                if (sys_pause_req)                      state_next = PAUSING;
                else if (!tx_pause_ack && !rx_pause_ack) state_next = RUN;
            end
            default: state_next = HALTED;
        endcase

        if (take)                pending_next = 1'b1;
        else if (state == APPLY) pending_next = 1'b0;

        pause_req_next = !((state_next == RUN) || (state_next == RESUMING));
        sys_ack_next   = (state_next == HALTED);
        busy_next      = (state_next != RUN);
        ready_next     = ((state_next == RUN) || (state_next == HALTED)) && !pending_next;
        err_next       = accept && !legal;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_pause_req  <= 1'b1;
            rx_pause_req  <= 1'b1;
            sys_pause_ack <= 1'b1;
            cfg_ready     <= 1'b1;
            cfg_err       <= 1'b0;
            busy          <= 1'b1;
        end else begin
            tx_pause_req  <= pause_req_next;
            rx_pause_req  <= pause_req_next;
            sys_pause_ack <= sys_ack_next;
            cfg_ready     <= ready_next;
            cfg_err       <= err_next;
            busy          <= busy_next;
        end
    end

    // Shadow copy of the last legal write, held until the engines are paused.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_parity_sel <= 1'b0;
            sh_parity_ctl <= 1'b0;
            sh_stop_bits  <= 1'b0;
            sh_data_len   <= DLEN_RST;
            sh_baud       <= BAUD_RST;
        end else if (take) begin
            sh_parity_sel <= cfg_parity_sel;
            sh_parity_ctl <= cfg_parity_ctl;
            sh_stop_bits  <= cfg_stop_bits;
            sh_data_len   <= cfg_data_len;
            sh_baud       <= cfg_baud;
        end
    end

    // Live config only moves on the APPLY cycle, when both engines are known idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_select  <= 1'b0;
            parity_control <= 1'b0;
            stop_bits      <= 1'b0;
            data_length    <= DLEN_RST;
            baud_rate      <= BAUD_RST;
        end else if (state == APPLY) begin
            parity_select  <= sh_parity_sel;
            parity_control <= sh_parity_ctl;
            stop_bits      <= sh_stop_bits;
            data_length    <= sh_data_len;
            baud_rate      <= sh_baud;
        end
    end

endmodule

// File: tb/tb_adam_periph_uart_cfg_ctrl.sv
// Scoreboard bench for adam_periph_uart_cfg_ctrl: directed protocol scenarios followed by
// randomized host writes and system pauses against paused-engine responders.
module tb_adam_periph_uart_cfg_ctrl;

    localparam int unsigned DW = 32;

    typedef struct packed {
        logic          ps;
        logic          pc;
        logic          sb;
        logic [3:0]    len;
        logic [DW-1:0] baud;
    } cfg_t;

    typedef struct {
        bit          is_err;
        int unsigned due;
        cfg_t        cfg;
    } exp_t;

    localparam cfg_t RST_CFG = '{ps: 1'b0, pc: 1'b0, sb: 1'b0, len: 4'd8, baud: 32'd868};

    logic          clk = 1'b0;
    logic          rst;
    logic          sys_pause_req, sys_pause_ack;
    logic          cfg_valid, cfg_ready;
    logic          cfg_parity_sel, cfg_parity_ctl, cfg_stop_bits;
    logic [3:0]    cfg_data_len;
    logic [DW-1:0] cfg_baud;
    logic          cfg_err, busy;
    logic          tx_pause_req, rx_pause_req;
    logic          tx_pause_ack, rx_pause_ack;
    logic          parity_select, parity_control, stop_bits;
    logic [3:0]    data_length;
    logic [DW-1:0] baud_rate;

    cfg_t          live_now;
    assign live_now = {parity_select, parity_control, stop_bits, data_length, baud_rate};

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc   = 0;
    exp_t        q[$];
    cfg_t        model_live;
    bit          mon_en = 1'b0;

    adam_periph_uart_cfg_ctrl dut (
        .clk(clk), .rst(rst),
        .sys_pause_req(sys_pause_req), .sys_pause_ack(sys_pause_ack),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_parity_sel(cfg_parity_sel), .cfg_parity_ctl(cfg_parity_ctl),
        .cfg_data_len(cfg_data_len), .cfg_stop_bits(cfg_stop_bits), .cfg_baud(cfg_baud),
        .cfg_err(cfg_err), .busy(busy),
        .tx_pause_req(tx_pause_req), .rx_pause_req(rx_pause_req),
        .tx_pause_ack(tx_pause_ack), .rx_pause_ack(rx_pause_ack),
        .parity_select(parity_select), .parity_control(parity_control),
        .stop_bits(stop_bits), .data_length(data_length), .baud_rate(baud_rate)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine responders: ack follows req after a programmable number of cycles.
    int unsigned tx_dly = 2, rx_dly = 2, tx_cnt = 0, rx_cnt = 0;
    always @(posedge clk) begin
        if (rst) begin
            tx_pause_ack <= 1'b1; tx_cnt <= 0;
        end else if (tx_pause_ack != tx_pause_req) begin
            if (tx_cnt + 1 >= tx_dly) begin tx_pause_ack <= tx_pause_req; tx_cnt <= 0; end
            else tx_cnt <= tx_cnt + 1;
        end else tx_cnt <= 0;
    end
    always @(posedge clk) begin
        if (rst) begin
            rx_pause_ack <= 1'b1; rx_cnt <= 0;
        end else if (rx_pause_ack != rx_pause_req) begin
            if (rx_cnt + 1 >= rx_dly) begin rx_pause_ack <= rx_pause_req; rx_cnt <= 0; end
            else rx_cnt <= rx_cnt + 1;
        end else rx_cnt <= 0;
    end

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endfunction

    function automatic bit legal_cfg(cfg_t c);
        return (c.len >= 4'd5) && (c.len <= 4'd9) && (c.baud >= 32'd2);
    endfunction

    // Called on the negedge before the posedge where valid&&ready is sampled.
    function automatic void note_accept(cfg_t c);
        exp_t e;
        e.cfg = c;
        if (legal_cfg(c)) begin
            e.is_err = 1'b0; e.due = cyc + 2; model_live = c;
        end else begin
            e.is_err = 1'b1; e.due = cyc + 1;
        end
        q.push_back(e);
    endfunction

    // Monitor: cfg_err pulses and live-config changes each consume one scoreboard entry.
    cfg_t prev_live;
    bit   prev_paused = 1'b0;
    exp_t m_e;
    always @(negedge clk) begin
        if (mon_en) begin
            if (cfg_err === 1'b1) begin
                if (q.size() == 0 || !q[0].is_err) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_err: got cfg_err=1 at cycle %0d, required no error pulse", cyc);
                end else begin
                    m_e = q.pop_front();
                    check("err_timing", 64'(cyc), 64'(m_e.due));
                end
            end
            if (live_now !== prev_live) begin
                if (q.size() == 0 || q[0].is_err) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_live_change: got 0x%0h, required unchanged 0x%0h",
                             live_now, prev_live);
                end else begin
                    m_e = q.pop_front();
                    check("live_cfg", 64'(live_now), 64'(m_e.cfg));
                    check("apply_while_paused", 64'(prev_paused), 64'(1));
                    check("acks_after_apply", 64'({tx_pause_ack, rx_pause_ack}), 64'(2'b11));
                    check("apply_latency", 64'(cyc >= m_e.due), 64'(1));
                end
            end
            if (sys_pause_ack === 1'b1)
                check("halted_engines_paused",
                      64'({tx_pause_req, rx_pause_req, tx_pause_ack, rx_pause_ack}), 64'(4'hf));
        end
        prev_live   = live_now;
        prev_paused = tx_pause_req && rx_pause_req && tx_pause_ack && rx_pause_ack;
    end

    task automatic drive_cfg(input cfg_t c);
        cfg_parity_sel = c.ps;
        cfg_parity_ctl = c.pc;
        cfg_stop_bits  = c.sb;
        cfg_data_len   = c.len;
        cfg_baud       = c.baud;
    endtask

    // Present one write and hold it until accepted; returns on the negedge after acceptance.
    task automatic issue(input cfg_t c);
        bit done;
        done = 1'b0;
        drive_cfg(c);
        cfg_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            if (cfg_ready) begin note_accept(c); done = 1'b1; end
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL issue_accept: got cfg_ready=0 for 200 cycles, required acceptance");
        end
    endtask

    task automatic wait_run(input int bound);
        for (int i = 0; i < bound && busy; i++) @(negedge clk);
    endtask

    task automatic wait_drain(input int bound);
        for (int i = 0; i < bound && q.size() != 0; i++) @(negedge clk);
        check("queue_drained", 64'(q.size()), 64'(0));
    endtask

    initial begin
        cfg_t c;
        bit   saw_ready, acc;

        rst = 1'b1; sys_pause_req = 1'b0; cfg_valid = 1'b0;
        drive_cfg(RST_CFG);
        model_live = RST_CFG;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_busy", 64'(busy), 64'(1));
        check("rst_sys_ack", 64'(sys_pause_ack), 64'(1));
        check("rst_ready", 64'(cfg_ready), 64'(1));
        check("rst_err", 64'(cfg_err), 64'(0));
        check("rst_pause_req", 64'({tx_pause_req, rx_pause_req}), 64'(2'b11));
        check("rst_live", 64'(live_now), 64'(RST_CFG));

        // Release into RUN.
        rst = 1'b0;
        mon_en = 1'b1;
        wait_run(10);
        check("reach_run", 64'(busy), 64'(0));
        check("run_live_default", 64'(live_now), 64'(RST_CFG));
        check("run_pause_req", 64'({tx_pause_req, rx_pause_req}), 64'(2'b00));

        // Legal write from RUN with staggered engine acks.
        tx_dly = 3; rx_dly = 10;
        c = '{ps: 1'b0, pc: 1'b1, sb: 1'b0, len: 4'd7, baud: 32'd434};
        issue(c);
        check("pause_req_after_write", 64'({tx_pause_req, rx_pause_req}), 64'(2'b11));
        saw_ready = 1'b0;
        for (int i = 0; i < 80 && busy; i++) begin
            saw_ready |= cfg_ready;
            @(negedge clk);
        end
        check("ready_low_during_update", 64'(saw_ready), 64'(0));
        check("back_to_run", 64'(busy), 64'(0));
        check("live_after_write", 64'(live_now), 64'(c));
        wait_drain(10);

        // Illegal writes: length too short, too long, baud too small.
        tx_dly = 2; rx_dly = 2;
        c = model_live; c.len = 4'd4;  issue(c);
        c = model_live; c.len = 4'd10; issue(c);
        c = model_live; c.baud = 32'd1; issue(c);
        repeat (2) @(negedge clk);
        wait_drain(10);
        check("illegal_stays_run", 64'(busy), 64'(0));
        check("illegal_live_kept", 64'(live_now), 64'(model_live));

        // System pause and a write in the same cycle.
        sys_pause_req = 1'b1;
        c = '{ps: 1'b1, pc: 1'b0, sb: 1'b1, len: 4'd9, baud: 32'd2};
        issue(c);
        for (int i = 0; i < 60 && !sys_pause_ack; i++) @(negedge clk);
        check("combined_halt_ack", 64'(sys_pause_ack), 64'(1));
        check("combined_live", 64'(live_now), 64'(c));
        check("combined_ready", 64'(cfg_ready), 64'(1));
        sys_pause_req = 1'b0;
        wait_run(40);
        check("combined_resume", 64'(busy), 64'(0));
        check("combined_sys_ack_drop", 64'(sys_pause_ack), 64'(0));
        wait_drain(5);

        // Reset while a write waits in PAUSING.
        tx_dly = 20; rx_dly = 20;
        c = '{ps: 1'b0, pc: 1'b0, sb: 1'b1, len: 4'd5, baud: 32'd1000};
        issue(c);
        repeat (3) @(negedge clk);
        check("pausing_before_rst", 64'({busy, tx_pause_req, sys_pause_ack}), 64'(3'b110));
        mon_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        q.delete();
        model_live = RST_CFG;
        check("midrst_live", 64'(live_now), 64'(RST_CFG));
        check("midrst_halted", 64'({busy, sys_pause_ack, cfg_ready}), 64'(3'b111));
        sys_pause_req = 1'b1;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_pending_dropped", 64'(live_now), 64'(RST_CFG));
        check("midrst_ready", 64'(cfg_ready), 64'(1));
        check("midrst_stay_halted", 64'(sys_pause_ack), 64'(1));
        mon_en = 1'b1;

        // Randomized writes, pauses and engine latencies.
        tx_dly = $urandom_range(1, 6); rx_dly = $urandom_range(1, 6);
        acc = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (acc) begin cfg_valid = 1'b0; acc = 1'b0; end
            if ($urandom_range(0, 29) == 0) sys_pause_req = ~sys_pause_req;
            if ($urandom_range(0, 49) == 0) begin
                tx_dly = $urandom_range(1, 6); rx_dly = $urandom_range(1, 6);
            end
            if (!cfg_valid && $urandom_range(0, 3) == 0) begin
                c.ps   = 1'($urandom);
                c.pc   = 1'($urandom);
                c.sb   = 1'($urandom);
                c.len  = 4'($urandom_range(3, 11));
                c.baud = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 1))
                                                     : 32'($urandom_range(2, 5000));
                if (legal_cfg(c) && c == model_live) c.baud = c.baud + 32'd1;
                drive_cfg(c);
                cfg_valid = 1'b1;
            end
            if (cfg_valid && cfg_ready) begin note_accept(c); acc = 1'b1; end
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        sys_pause_req = 1'b0;
        wait_drain(300);
        wait_run(100);
        check("final_run", 64'(busy), 64'(0));
        check("final_live", 64'(live_now), 64'(model_live));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
